decode_rename_fifo: RTL and testbench
=====================================

DECODE_RENAME_FIFO -- requirements
Module: decode_rename_fifo

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, 4..64.
REQ-002 Parameter PAYLOAD_W, default 189, width of one packed decoded-instruction payload.
REQ-003 Parameter LANES, default 2, enqueue/dequeue lanes per cycle; legal values 1 or 2.
REQ-004 CLK  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 FLUSH  in  1  discard all entries (mispredict/exception recovery).
REQ-007 STALL  in  1  global pipeline freeze.
REQ-008 enq_valid  in  LANES  per-lane valid from decode.
REQ-009 enq_payload  in  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-010 enq_ready  out  LANES  lane i ready when free entries > i.
REQ-011 deq_valid  out  LANES  lane i valid when occupancy > i.
REQ-012 deq_payload  out  LANES*PAYLOAD_W  lane i = entry at head+i; zero when lane i not valid.
REQ-013 deq_ready  in  LANES  per-lane accept from rename.
REQ-014 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-016 Circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; no entry shifting.
REQ-017 Lanes are in order: lane 1 enqueue SHALL occur only if lane 0 enqueues the same cycle; lane 1 dequeue likewise; a lane-1 handshake without lane 0 SHALL be ignored.
REQ-018 Enqueue on lane i when enq_valid[i] && enq_ready[i]; payload written at tail+i; tail advances by number enqueued.
REQ-019 Dequeue on lane i when deq_valid[i] && deq_ready[i]; head advances by number dequeued.
REQ-020 deq_valid/deq_payload SHALL be combinational from current state (first-word fall-through); enqueued data visible at deq side the cycle after the write; no same-cycle bypass when empty.
REQ-021 enq_ready SHALL depend on current count only; a full queue SHALL NOT accept in a cycle where it also dequeues.
REQ-022 count_next = count + enqueued - dequeued; SHALL never exceed DEPTH or go below 0.
REQ-023 STALL=1 (FLUSH=0): no pointer, count or storage change; enq_ready and deq_valid SHALL be forced 0.
REQ-024 FLUSH=1: head=tail=0, count=0 next cycle, regardless of STALL; same-cycle enqueue and dequeue SHALL be discarded.
REQ-025 Priority: RESET > FLUSH > STALL > normal operation.

Reset
REQ-026 RESET asserted: head, tail, count=0 immediately; deq_valid=0, deq_payload=0, enq_ready=all ones (when not STALL), empty=1, full=0.
REQ-027 Storage contents need not be cleared; deq_payload masking (REQ-012) SHALL hide stale data.
REQ-028 Reset mid-operation SHALL abort any in-flight handshake; no entry survives.

Configuration
REQ-029 Macro DECODE_RENAME_FIFO_HWM_EN defined: adds output hwm ($clog2(DEPTH+1) bits) = maximum count observed since last RESET or FLUSH, updated with count_next, cleared to 0 by both.
REQ-030 Macro undefined: hwm port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package decode_rename_pkg SHALL hold: rename_payload_t packed struct (instr 32, pc 32, opA 32, opB 32, rs 5, rt 5, rd 5, mem_wdata 32, reg_write 1, alu_ctrl 6, mem_read 1, mem_write 1, shamt 5 = 189 bits) and default DEPTH/LANES constants.
REQ-032 One sub-module decode_rename_fifo_ram: DEPTH x PAYLOAD_W storage, LANES write ports, LANES async read ports; pointer/count logic stays in the top.

Verification
REQ-033 Reset, then enqueue 8 single-lane payloads 0x1..0x8 (DEPTH=8) -> full=1, enq_ready=00, count=8; dequeue order 0x1..0x8.
REQ-034 Dual-lane: enq A,B same cycle into empty -> next cycle deq_valid=11, lane0=A, lane1=B; deq_ready=11 -> empty=1 following cycle.
REQ-035 Wrap: fill 6, drain 5, enqueue 6 more -> count=7, pointers wrap, order preserved across index 7->0.
REQ-036 count=7: enq_valid=11 -> only lane 0 accepted (enq_ready=01), count=8; full with deq_ready=01 and enq_valid=01 -> count=7, no enqueue.
REQ-037 count=5, STALL=1 and FLUSH=1 together -> count=0 next cycle; STALL=1 alone for 3 cycles -> count stays 5, deq_valid=00.
REQ-038 With DECODE_RENAME_FIFO_HWM_EN: reach count 6, drain to 2 -> hwm=6; FLUSH -> hwm=0.

Source files
------------

// File: rtl/decode_rename_fifo_pkg.sv
// Shared types and defaults for the decode->rename instruction queue.
// Payload layout matches the decode stage's packed output, instr in the MSBs.
package decode_rename_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] mem_wdata;
    logic        reg_write;
    logic [5:0]  alu_ctrl;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  shamt;
  } rename_payload_t;

  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_LANES     = 2;
  localparam int RENAME_PAYLOAD_W  = $bits(rename_payload_t);

endpackage

// File: rtl/decode_rename_fifo_ram.sv
// Queue storage: LANES synchronous write ports, LANES combinational read ports.
// Write lands on the rising edge; no reset, stale words are masked by the caller.
module decode_rename_fifo_ram
  import decode_rename_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PAYLOAD_W = RENAME_PAYLOAD_W,
  parameter int LANES     = DEFAULT_LANES,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic [LANES-1:0]           wr_en,
  input  logic [LANES*PTR_W-1:0]     wr_addr,
  input  logic [LANES*PAYLOAD_W-1:0] wr_data,
  input  logic [LANES*PTR_W-1:0]     rd_addr,
  output logic [LANES*PAYLOAD_W-1:0] rd_data
);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];

  // Lanes always target distinct consecutive slots, so write ports never collide.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_addr[i*PTR_W +: PTR_W]] <= wr_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data[i*PAYLOAD_W +: PAYLOAD_W] = mem_q[rd_addr[i*PTR_W +: PTR_W]];
    end
  end

endmodule

// File: rtl/decode_rename_fifo.sv
// Multi-lane in-order decode->rename queue, first-word fall-through (write visible next cycle).
// Ready from occupancy only, STALL forces ready/valid low; DECODE_RENAME_FIFO_HWM_EN adds hwm.
module decode_rename_fifo
  import decode_rename_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PAYLOAD_W = RENAME_PAYLOAD_W,
  parameter int LANES     = DEFAULT_LANES
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         FLUSH,
  input  logic                         STALL,
  input  logic [LANES-1:0]             enq_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   enq_payload,
  output logic [LANES-1:0]             enq_ready,
  output logic [LANES-1:0]             deq_valid,
  output logic [LANES*PAYLOAD_W-1:0]   deq_payload,
  input  logic [LANES-1:0]             deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef DECODE_RENAME_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_rename_fifo: DEPTH must be a power of two in 4..64");
  end
  if (LANES < 1 || LANES > 2) begin : g_bad_lanes
    $error("decode_rename_fifo: LANES must be 1 or 2");
  end

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] num_enq, num_deq;
  logic [LANES-1:0] enq_fire, deq_fire;
  logic             enq_chain, deq_chain;
  logic [LANES*PTR_W-1:0]     wr_addr, rd_addr;
  logic [LANES*PAYLOAD_W-1:0] rd_data;

  // A lane only fires if every lower lane fired, keeping lanes strictly in order.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count_q;
    enq_ready  = '0;
    deq_valid  = '0;
    enq_fire   = '0;
    deq_fire   = '0;
    num_enq    = '0;
    num_deq    = '0;
    enq_chain  = 1'b1;
    deq_chain  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      enq_ready[i] = !STALL && (free_slots > CNT_W'(i));
      deq_valid[i] = !STALL && (count_q > CNT_W'(i));
      enq_fire[i]  = enq_chain && enq_valid[i] && enq_ready[i] && !FLUSH;
      deq_fire[i]  = deq_chain && deq_ready[i] && deq_valid[i] && !FLUSH;
      enq_chain    = enq_fire[i];
      deq_chain    = deq_fire[i];
      num_enq      = num_enq + CNT_W'(enq_fire[i]);
      num_deq      = num_deq + CNT_W'(deq_fire[i]);
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(num_deq);
    tail_d  = tail_q + PTR_W'(num_enq);
    count_d = count_q + num_enq - num_deq;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_addr[i*PTR_W +: PTR_W] = tail_q + PTR_W'(i);
      rd_addr[i*PTR_W +: PTR_W] = head_q + PTR_W'(i);
    end
  end

  decode_rename_fifo_ram #(
    .DEPTH     (DEPTH),
    .PAYLOAD_W (PAYLOAD_W),
    .LANES     (LANES),
    .PTR_W     (PTR_W)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (enq_fire),
    .wr_addr (wr_addr),
    .wr_data (enq_payload),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Storage is never cleared, so invalid lanes must be masked to hide stale words.
  always_comb begin
    deq_payload = '0;
    for (int i = 0; i < LANES; i++) begin
      if (deq_valid[i]) begin
        deq_payload[i*PAYLOAD_W +: PAYLOAD_W] = rd_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef DECODE_RENAME_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    if (FLUSH) begin
      hwm_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_decode_rename_fifo.sv
// Directed vector bench for decode_rename_fifo at DEPTH=8, LANES=2, 189-bit payload.
module tb_decode_rename_fifo;
  import decode_rename_pkg::*;

  localparam int PW = 189;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          stall;
  logic [1:0]    enq_valid;
  logic [2*PW-1:0] enq_payload;
  logic [1:0]    enq_ready;
  logic [1:0]    deq_valid;
  logic [2*PW-1:0] deq_payload;
  logic [1:0]    deq_ready;
  logic [3:0]    count;
  logic          full;
  logic          empty;
`ifdef DECODE_RENAME_FIFO_HWM_EN
  logic [3:0]    hwm;
`endif

  int checks = 0;
  int errors = 0;

  decode_rename_fifo dut (
    .CLK         (clk),
    .RESET       (rst),
    .FLUSH       (flush),
    .STALL       (stall),
    .enq_valid   (enq_valid),
    .enq_payload (enq_payload),
    .enq_ready   (enq_ready),
    .deq_valid   (deq_valid),
    .deq_payload (deq_payload),
    .deq_ready   (deq_ready),
    .count       (count),
    .full        (full),
    .empty       (empty)
`ifdef DECODE_RENAME_FIFO_HWM_EN
    ,
    .hwm         (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fl;
    logic        st;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  dr;
    logic [3:0]  cnt;
    logic [1:0]  er;
    logic [1:0]  dv;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic st, input logic [1:0] ev,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] dr,
                     input logic [3:0] cnt, input logic [1:0] er, input logic [1:0] dv,
                     input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.fl = fl; v.st = st; v.ev = ev; v.e0 = e0; v.e1 = e1; v.dr = dr;
    v.cnt = cnt; v.er = er; v.dv = dv; v.d0 = d0; v.d1 = d1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic st, input logic [1:0] ev,
                       input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [1:0] dr);
    flush       = fl;
    stall       = st;
    enq_valid   = ev;
    enq_payload = {p1, p0};
    deq_ready   = dr;
  endtask

  task automatic check_idle_reset_state(input string tag);
    check({tag, "_count"}, 256'(count), 256'(0));
    check({tag, "_empty"}, 256'(empty), 256'(1));
    check({tag, "_full"}, 256'(full), 256'(0));
    check({tag, "_enq_ready"}, 256'(enq_ready), 256'(2'b11));
    check({tag, "_deq_valid"}, 256'(deq_valid), 256'(2'b00));
    check({tag, "_deq_payload"}, 256'(deq_payload), 256'(0));
  endtask

  initial begin
    rename_payload_t p;
    rename_payload_t q;

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);

    // Vector table: inputs applied for one cycle; expectations are the outputs
    // seen while those inputs are held, i.e. the state before that edge.
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 2'b01, 32'(k), 0, 2'b00, 4'(k - 1),
          (k == 8) ? 2'b01 : 2'b11,
          (k == 1) ? 2'b00 : ((k == 2) ? 2'b01 : 2'b11),
          (k == 1) ? 32'd0 : 32'd1,
          (k <= 2) ? 32'd0 : 32'd2);
    end
    add(0, 0, 2'b01, 32'h99, 0, 2'b00, 8, 2'b00, 2'b11, 1, 2);
    for (int c = 8; c >= 1; c--) begin
      add(0, 0, 2'b00, 0, 0, 2'b01, 4'(c),
          (c == 8) ? 2'b00 : ((c == 7) ? 2'b01 : 2'b11),
          (c == 1) ? 2'b01 : 2'b11,
          32'(9 - c),
          (c == 1) ? 32'd0 : 32'(10 - c));
    end
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'hA, 32'hB, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b00, 0, 0, 2'b11, 2, 2'b11, 2'b11, 32'hA, 32'hB);
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'h11, 32'h12, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'h13, 32'h14, 2'b00, 2, 2'b11, 2'b11, 32'h11, 32'h12);
    add(0, 0, 2'b11, 32'h15, 32'h16, 2'b00, 4, 2'b11, 2'b11, 32'h11, 32'h12);
    add(0, 0, 2'b00, 0, 0, 2'b11, 6, 2'b11, 2'b11, 32'h11, 32'h12);
    add(0, 0, 2'b00, 0, 0, 2'b11, 4, 2'b11, 2'b11, 32'h13, 32'h14);
    add(0, 0, 2'b00, 0, 0, 2'b01, 2, 2'b11, 2'b11, 32'h15, 32'h16);
    add(0, 0, 2'b11, 32'h21, 32'h22, 2'b00, 1, 2'b11, 2'b01, 32'h16, 0);
    add(0, 0, 2'b11, 32'h23, 32'h24, 2'b00, 3, 2'b11, 2'b11, 32'h16, 32'h21);
    add(0, 0, 2'b11, 32'h25, 32'h26, 2'b00, 5, 2'b11, 2'b11, 32'h16, 32'h21);
    add(0, 0, 2'b11, 32'h31, 32'h32, 2'b00, 7, 2'b01, 2'b11, 32'h16, 32'h21);
    add(0, 0, 2'b01, 32'h33, 0, 2'b01, 8, 2'b00, 2'b11, 32'h16, 32'h21);
    add(0, 0, 2'b00, 0, 0, 2'b00, 7, 2'b01, 2'b11, 32'h21, 32'h22);
    add(0, 0, 2'b00, 0, 0, 2'b11, 7, 2'b01, 2'b11, 32'h21, 32'h22);
    add(0, 0, 2'b00, 0, 0, 2'b11, 5, 2'b11, 2'b11, 32'h23, 32'h24);
    add(0, 0, 2'b00, 0, 0, 2'b11, 3, 2'b11, 2'b11, 32'h25, 32'h26);
    add(0, 0, 2'b00, 0, 0, 2'b11, 1, 2'b11, 2'b01, 32'h31, 0);
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b10, 0, 32'h55, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'h41, 32'h42, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'h43, 32'h44, 2'b00, 2, 2'b11, 2'b11, 32'h41, 32'h42);
    add(0, 0, 2'b01, 32'h45, 0, 2'b00, 4, 2'b11, 2'b11, 32'h41, 32'h42);
    for (int s = 0; s < 3; s++) begin
      add(0, 1, 2'b11, 32'h77, 32'h78, 2'b11, 5, 2'b00, 2'b00, 0, 0);
    end
    add(0, 0, 2'b00, 0, 0, 2'b00, 5, 2'b11, 2'b11, 32'h41, 32'h42);
    add(1, 1, 2'b11, 32'h79, 32'h7A, 2'b11, 5, 2'b00, 2'b00, 0, 0);
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b11, 32'h61, 32'h62, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(1, 0, 2'b11, 32'h63, 32'h64, 2'b11, 2, 2'b11, 2'b11, 32'h61, 32'h62);
    add(0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b01, 32'h71, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0);
    add(0, 0, 2'b00, 0, 0, 2'b00, 1, 2'b11, 2'b01, 32'h71, 0);

    // Reset state
    @(negedge clk);
    #1;
    check_idle_reset_state("reset");
`ifdef DECODE_RENAME_FIFO_HWM_EN
    check("reset_hwm", 256'(hwm), 256'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].st, vecs[i].ev, PW'(vecs[i].e0), PW'(vecs[i].e1), vecs[i].dr);
      #1;
      check($sformatf("v%0d_count", i), 256'(count), 256'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 256'(full), 256'(vecs[i].cnt == 4'd8));
      check($sformatf("v%0d_empty", i), 256'(empty), 256'(vecs[i].cnt == 4'd0));
      check($sformatf("v%0d_enq_ready", i), 256'(enq_ready), 256'(vecs[i].er));
      check($sformatf("v%0d_deq_valid", i), 256'(deq_valid), 256'(vecs[i].dv));
      check($sformatf("v%0d_deq_lane0", i), 256'(deq_payload[PW-1:0]), 256'(vecs[i].d0));
      check($sformatf("v%0d_deq_lane1", i), 256'(deq_payload[2*PW-1:PW]), 256'(vecs[i].d1));
    end

    // Full-width payload integrity through both lanes
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, '0, '0, 2'b00);
    p = '{instr: 32'hDEADBEEF, pc: 32'h8000_0004, op_a: 32'hCAFEF00D, op_b: 32'h1234_5678,
          rs: 5'd31, rt: 5'd1, rd: 5'd17, mem_wdata: 32'hA5A5_5A5A, reg_write: 1'b1,
          alu_ctrl: 6'h2A, mem_read: 1'b0, mem_write: 1'b1, shamt: 5'd19};
    q = ~p;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, p, q, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    #1;
    check("wide_deq_valid", 256'(deq_valid), 256'(2'b11));
    check("wide_lane0", 256'(deq_payload[PW-1:0]), 256'(p));
    check("wide_lane1", 256'(deq_payload[2*PW-1:PW]), 256'(q));
    check("wide_count", 256'(count), 256'(2));

    // Asynchronous reset mid-cycle with handshakes pending on both sides
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, p, q, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset_state("midrst");
    @(negedge clk);
    #1;
    check_idle_reset_state("midrst_held");
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    @(negedge clk);
    #1;
    check_idle_reset_state("midrst_after");

`ifdef DECODE_RENAME_FIFO_HWM_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b11, PW'(k), PW'(k + 100), 2'b00);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b11);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    #1;
    check("hwm_count", 256'(count), 256'(2));
    check("hwm_peak", 256'(hwm), 256'(6));
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, '0, '0, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    #1;
    check("hwm_flush_count", 256'(count), 256'(0));
    check("hwm_flush", 256'(hwm), 256'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
